// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with divide-by-zero and signed-overflow cases resolved at accept.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic [2:0]  op_r;
  logic [4:0]  rd_r;
  logic        sign_a_r;
  logic        sign_x_r;
  logic        special_r;
  logic [31:0] special_val_r;
  logic [63:0] mcand_r;
  logic [31:0] mplier_r;
  logic [63:0] acc_r;
  logic [31:0] divisor_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;

  logic        is_div_s;
  logic        a_signed_s;
  logic        b_signed_s;
  logic        sign_a_s;
  logic        sign_b_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic        div_zero_s;
  logic        div_ovf_s;
  logic        special_s;
  logic [31:0] special_val_s;

  logic [32:0] div_shift_s;
  logic [32:0] div_trial_s;
  logic [63:0] prod_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;
  logic [31:0] fin_val_s;

  // Accept-time decode: operand signedness, magnitudes and special-divide results.
  always_comb begin
    is_div_s = funct3[2];
    if (is_div_s) begin
      a_signed_s = ~funct3[0];
      b_signed_s = ~funct3[0];
    end else begin
      a_signed_s = (funct3[1:0] != 2'b11);
      b_signed_s = ~funct3[1];
    end
    sign_a_s   = a_signed_s & operand_a[31];
    sign_b_s   = b_signed_s & operand_b[31];
    mag_a_s    = sign_a_s ? neg32(operand_a) : operand_a;
    mag_b_s    = sign_b_s ? neg32(operand_b) : operand_b;
    div_zero_s = is_div_s & (operand_b == 32'd0);
    div_ovf_s  = is_div_s & ~funct3[0] & (operand_a == 32'h8000_0000) &
                 (operand_b == 32'hFFFF_FFFF);
    special_s  = div_zero_s | div_ovf_s;
    if (div_zero_s) begin
      special_val_s = funct3[1] ? operand_a : 32'hFFFF_FFFF;
    end else if (div_ovf_s) begin
      special_val_s = funct3[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      special_val_s = 32'd0;
    end
  end

  // Restoring-divide trial subtraction and final sign fix-up of the selected result.
  always_comb begin
    div_shift_s = {rem_r, quo_r[31]};
    div_trial_s = div_shift_s - {1'b0, divisor_r};
    prod_s      = sign_x_r ? neg64(acc_r) : acc_r;
    quo_fix_s   = sign_x_r ? neg32(quo_r) : quo_r;
    rem_fix_s   = sign_a_r ? neg32(rem_r) : rem_r;
    if (special_r) begin
      fin_val_s = special_val_r;
    end else if (op_r[2]) begin
      fin_val_s = op_r[1] ? rem_fix_s : quo_fix_s;
    end else if (op_r[1:0] == 2'b00) begin
      fin_val_s = prod_s[31:0];
    end else begin
      fin_val_s = prod_s[63:32];
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_r       <= IDLE;
      cnt_r         <= 5'd0;
      op_r          <= 3'd0;
      rd_r          <= 5'd0;
      sign_a_r      <= 1'b0;
      sign_x_r      <= 1'b0;
      special_r     <= 1'b0;
      special_val_r <= 32'd0;
      mcand_r       <= 64'd0;
      mplier_r      <= 32'd0;
      acc_r         <= 64'd0;
      divisor_r     <= 32'd0;
      rem_r         <= 32'd0;
      quo_r         <= 32'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= 32'd0;
      rd_out        <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !kill) begin
            op_r          <= funct3;
            rd_r          <= rd_in;
            sign_a_r      <= sign_a_s;
            sign_x_r      <= sign_a_s ^ sign_b_s;
            special_r     <= special_s;
            special_val_r <= special_val_s;
            cnt_r         <= 5'd0;
            mcand_r       <= {32'd0, mag_a_s};
            mplier_r      <= mag_b_s;
            acc_r         <= 64'd0;
            divisor_r     <= mag_b_s;
            rem_r         <= 32'd0;
            quo_r         <= mag_a_s;
            busy          <= 1'b1;
            if (special_s) begin
              state_r <= FIN;
            end else if (funct3[2]) begin
              state_r <= DIV;
            end else begin
              state_r <= MUL;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        MUL: begin
          if (kill) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            if (mplier_r[0]) begin
              acc_r <= acc_r + mcand_r;
            end else begin
              acc_r <= acc_r;
            end
            mcand_r  <= {mcand_r[62:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[31:1]};
            cnt_r    <= cnt_r + 5'd1;
            if (cnt_r == 5'd31) begin
              state_r <= FIN;
            end else begin
              state_r <= MUL;
            end
          end
        end
        DIV: begin
          if (kill) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            if (!div_trial_s[32]) begin
              rem_r <= div_trial_s[31:0];
              quo_r <= {quo_r[30:0], 1'b1};
            end else begin
              rem_r <= div_shift_s[31:0];
              quo_r <= {quo_r[30:0], 1'b0};
            end
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r == 5'd31) begin
              state_r <= FIN;
            end else begin
              state_r <= DIV;
            end
          end
        end
        FIN: begin
          // busy stays high through the done cycle and drops from IDLE afterwards.
          state_r <= IDLE;
          if (kill) begin
            busy <= 1'b0;
          end else begin
            done   <= 1'b1;
            result <= fin_val_s;
            rd_out <= rd_r;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit; a queue-based scoreboard checks every done
// strobe for result, rd_out and completion cycle.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] last_res = 32'd0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sb[$];

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .RST(RST), .start(start), .kill(kill), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int t0);
    @(posedge clk); #1;
    funct3 = f; operand_a = a; operand_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int lat, input int restart_at);
    int t0;
    bit busy_ok;
    exp_t e;
    busy_ok = 1'b1;
    issue(f, a, b, rd, t0);
    e.res = exp; e.rd = rd; e.cyc = t0 + lat; e.name = name;
    sb.push_back(e);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (k == restart_at) begin
        start = 1'b1; funct3 = 3'b100; operand_a = 32'd100; operand_b = 32'd3; rd_in = 5'd31;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check({name, " busy_window"}, {31'd0, busy_ok}, 32'd1);
    check({name, " busy_after"}, {31'd0, busy}, 32'd0);
    check({name, " done_seen"}, sb.size(), 32'd0);
    last_res = exp;
  endtask

  task automatic kill_op();
    int t0;
    issue(3'b100, 32'd1000, 32'd7, 5'd3, t0);
    for (int k = 0; k <= 10; k++) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill busy_low", {31'd0, busy}, 32'd0);
    check("kill result_kept", result, last_res);
    repeat (40) @(negedge clk);
    check("kill result_still", result, last_res);
    check("kill busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic kill_start_op();
    @(negedge clk);
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; operand_a = 32'd9; operand_b = 32'd9; rd_in = 5'd20;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_start busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("kill_start busy_idle", {31'd0, busy}, 32'd0);
    check("kill_start result_kept", result, last_res);
  endtask

  task automatic rst_op();
    int t0;
    issue(3'b000, 32'h0000_1234, 32'h0000_5678, 5'd7, t0);
    for (int k = 0; k <= 20; k++) @(negedge clk);
    RST = 1'b1;
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst rd_out", {27'd0, rd_out}, 32'd0);
    repeat (2) @(negedge clk);
    RST = 1'b0;
    last_res = 32'd0;
    do_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 5'd9, 32'd12, 33, -1);
  endtask

  // Scoreboard monitor: every done must match the oldest pending expectation.
  initial begin
    exp_t e;
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        checks++;
        if (prev) begin
          errors++;
          $display("FAIL done_pulse: done high in consecutive cycles, required single-cycle pulse");
        end else if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: result=%h rd_out=%0d, required no done", result, rd_out);
        end else begin
          e = sb.pop_front();
          if (result !== e.res || rd_out !== e.rd || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s: result=%h rd_out=%0d cycle=%0d, required result=%h rd_out=%0d cycle=%0d",
                     e.name, result, rd_out, cyc, e.res, e.rd, e.cyc);
          end
        end
      end
      prev = (done === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", {27'd0, rd_out}, 32'd0);

    do_op("mul_7x-3",   3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, -1);
    do_op("mulhu_ff",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33, 5);
    do_op("mulh_ff",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 33, -1);
    do_op("mulhsu_ff",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 33, -1);
    do_op("mul_ff",     3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0001, 33, -1);
    do_op("div_-7/2",   3'b100, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 33, -1);
    do_op("rem_-7/2",   3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 33, -1);
    do_op("divu_-7/2",  3'b101, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'h7FFF_FFFC, 33, -1);
    do_op("remu_-7/2",  3'b111, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'h0000_0001, 33, -1);
    kill_op();
    kill_start_op();
    do_op("divu_5/0",   3'b101, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1, -1);
    do_op("rem_5/0",    3'b110, 32'd5,         32'd0,         5'd12, 32'h0000_0005, 1, -1);
    do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1, -1);
    do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1, -1);
    rst_op();

    repeat (5) @(negedge clk);
    check("final scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
